// File: rtl/serdes_pkg.sv
// serdes_pkg: shared types and helpers for the serial transmit path.
//   ser_state_t       : frame_serializer FSM states
//   SER_DEFAULT_WIDTH : default data bits per frame
//   ser_cnt_w()       : counter width able to hold 0..width+1
package serdes_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } ser_state_t;

  localparam int unsigned SER_DEFAULT_WIDTH = 10;

  function automatic int unsigned ser_cnt_w(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/frame_serializer_if.sv
// frame_serializer_if: word-in / bit-out bundle of the frame serializer.
//   din, din_valid, din_ready        : parallel word handshake (source -> serializer)
//   sout, sout_valid, frame_start    : serial link side
//   busy                             : frame in progress
// Modports: master = word source / link observer, slave = the serializer.
interface frame_serializer_if #(
  parameter int unsigned WIDTH = serdes_pkg::SER_DEFAULT_WIDTH
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, frame_start, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, frame_start, busy
  );
endinterface

// File: rtl/ser_bit_counter.sv
// ser_bit_counter: loadable up/down counter with terminal-count flag.
//   clk, rst   : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (priority over step)
//   load_val   : value to load
//   step       : advance one count (up, or down when DOWN=1)
//   tc         : count equals TERM
module ser_bit_counter #(
  parameter int unsigned     CW   = 4,
  parameter bit              DOWN = 1'b0,
  parameter logic [CW-1:0]   TERM = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          step,
  output logic          tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (step) begin
      if (DOWN) cnt <= cnt - CW'(1);
      else      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == TERM);

endmodule

// File: rtl/frame_serializer.sv
// frame_serializer: parallel-in / serial-out transmitter, MSB first, one bit
// per clock with en=1. Accepts a WIDTH-bit word on a valid/ready handshake,
// then idles GAP cycles after each frame before accepting the next word.
//   clk   : clock, all logic on posedge
//   rst   : synchronous active-high reset; discards any frame in progress
//   en    : bit-transfer enable (shared with the receiving shift register)
//   bus   : frame_serializer_if.slave (din/din_valid/din_ready, sout,
//           sout_valid, frame_start, busy); din_ready is combinational,
//           all other outputs registered
// Optional: define SER_PARITY_EN to append an even-parity bit after the LSB.
module frame_serializer
  import serdes_pkg::*;
#(
  parameter int unsigned WIDTH = SER_DEFAULT_WIDTH,
  parameter int unsigned GAP   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  frame_serializer_if.slave   bus
);

`ifdef SER_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned SW = NBITS - 1;
  localparam int unsigned CW = ser_cnt_w(WIDTH);
  localparam int unsigned GW = ser_cnt_w(GAP);
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  ser_state_t     state;
  // Holds only the bits still to be sent; the MSB goes straight to sout at
  // load, so each shift presents shreg[SW-1] as the next bit.
  logic [SW-1:0]  shreg;
  logic           sout_r;
  logic           sout_valid_r;
  logic           frame_start_r;
  logic           busy_r;

  logic           bit_load, bit_step, bit_tc;
  logic           gap_load, gap_step, gap_tc;

  assign bit_load = (state == S_IDLE) && bus.din_valid;
  assign bit_step = (state == S_SHIFT) && en && !bit_tc;
  assign gap_load = (state == S_SHIFT) && en && bit_tc;
  assign gap_step = (state == S_GAP) && !gap_tc;

  // Bits emitted so far in the frame; tc marks the last bit on sout.
  ser_bit_counter #(
    .CW   (CW),
    .DOWN (1'b0),
    .TERM (CW'(NBITS))
  ) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (bit_load),
    .load_val (CW'(1)),
    .step     (bit_step),
    .tc       (bit_tc)
  );

  // Idle cycles remaining after a frame; runs regardless of en.
  ser_bit_counter #(
    .CW   (GW),
    .DOWN (1'b1),
    .TERM ('0)
  ) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .step     (gap_step),
    .tc       (gap_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      shreg         <= '0;
      sout_r        <= 1'b0;
      sout_valid_r  <= 1'b0;
      frame_start_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      frame_start_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.din_valid) begin
`ifdef SER_PARITY_EN
            shreg <= {bus.din[WIDTH-2:0], ^bus.din};
`else
            shreg <= bus.din[WIDTH-2:0];
`endif
            sout_r        <= bus.din[WIDTH-1];
            sout_valid_r  <= 1'b1;
            frame_start_r <= 1'b1;
            busy_r        <= 1'b1;
            state         <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (en) begin
            if (!bit_tc) begin
              sout_r <= shreg[SW-1];
              shreg  <= shreg << 1;
            end else begin
              sout_r       <= 1'b0;
              sout_valid_r <= 1'b0;
              if (GAP > 0) begin
                state <= S_GAP;
              end else begin
                state  <= S_IDLE;
                busy_r <= 1'b0;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_tc) begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.din_ready   = (state == S_IDLE);
  assign bus.sout        = sout_r;
  assign bus.sout_valid  = sout_valid_r;
  assign bus.frame_start = frame_start_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: directed bench for frame_serializer.
// dut_a runs WIDTH=10/GAP=1, dut_b runs WIDTH=10/GAP=0 for back-to-back frames.
// Expected words are hand-computed, with the parity bit appended when
// SER_PARITY_EN is defined.
module tb_frame_serializer;

`ifdef SER_PARITY_EN
  localparam int unsigned NB    = 11;
  localparam logic [31:0] E_2B5 = 32'h56A;
  localparam logic [31:0] E_0C6 = 32'h18C;
  localparam logic [31:0] E_1A3 = 32'h347;
  localparam logic [31:0] E_007 = 32'h00F;
  localparam logic [31:0] E_003 = 32'h006;
`else
  localparam int unsigned NB    = 10;
  localparam logic [31:0] E_2B5 = 32'h2B5;
  localparam logic [31:0] E_0C6 = 32'h0C6;
  localparam logic [31:0] E_1A3 = 32'h1A3;
  localparam logic [31:0] E_007 = 32'h007;
  localparam logic [31:0] E_003 = 32'h003;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  frame_serializer_if #(.WIDTH(10)) if_a ();
  frame_serializer_if #(.WIDTH(10)) if_b ();

  frame_serializer #(.WIDTH(10), .GAP(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (if_a)
  );

  frame_serializer #(.WIDTH(10), .GAP(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (if_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Collects one frame from dut_a starting at the sample showing its first bit.
  // A bit is counted as transferred when sout_valid and en are both high at
  // the sample before an edge. Returns at the first invalid sample after the frame.
  task automatic capture(input bit toggle, output logic [31:0] word,
                         output int unsigned nx, output int unsigned nv,
                         output int unsigned ns, output bit ok);
    bit seen;
    word = '0; nx = 0; nv = 0; ns = 0; ok = 1'b0; seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      en = toggle ? ((i % 2) != 0) : 1'b1;
      if (if_a.frame_start) ns++;
      if (if_a.sout_valid) begin
        seen = 1'b1;
        nv++;
        if (en) begin
          word = {word[30:0], if_a.sout};
          nx++;
        end
      end else if (seen) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    en = 1'b1;
  endtask

  task automatic wait_ready_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (if_a.din_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic send_a(input logic [9:0] w);
    bit rdy;
    wait_ready_a(rdy);
    check("wait_ready", 32'(rdy), 32'd1);
    if_a.din       = w;
    if_a.din_valid = 1'b1;
    tick();
    if_a.din_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] word;
    int unsigned nx, nv, ns;
    bit          ok;
    logic        exp_sout;

    rst = 1'b1;
    en  = 1'b1;
    if_a.din = '0; if_a.din_valid = 1'b0;
    if_b.din = '0; if_b.din_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_sout",   32'(if_a.sout),        32'd0);
    check("rst_valid",  32'(if_a.sout_valid),  32'd0);
    check("rst_start",  32'(if_a.frame_start), 32'd0);
    check("rst_busy",   32'(if_a.busy),        32'd0);
    check("rst_ready",  32'(if_a.din_ready),   32'd1);
    check("rst_ready_b", 32'(if_b.din_ready),  32'd1);

    // Single word, en held high
    send_a(10'h2B5);
    check("t1_busy", 32'(if_a.busy), 32'd1);
    capture(1'b0, word, nx, nv, ns, ok);
    check("t1_done",  32'(ok), 32'd1);
    check("t1_word",  word, E_2B5);
    check("t1_xfer",  nx, NB);
    check("t1_valid", nv, NB);
    check("t1_start", ns, 32'd1);

    // Same word, en toggling: every bit held two cycles
    send_a(10'h2B5);
    capture(1'b1, word, nx, nv, ns, ok);
    check("t2_done",  32'(ok), 32'd1);
    check("t2_word",  word, E_2B5);
    check("t2_xfer",  nx, NB);
    check("t2_valid", nv, 2 * NB);
    check("t2_start", ns, 32'd1);

    // Word offered during S_GAP waits for S_IDLE
    check("t6_gap_busy",  32'(if_a.busy),      32'd1);
    check("t6_gap_ready", 32'(if_a.din_ready), 32'd0);
    if_a.din       = 10'h0C6;
    if_a.din_valid = 1'b1;
    tick();
    check("t6_idle_ready", 32'(if_a.din_ready),  32'd1);
    check("t6_idle_valid", 32'(if_a.sout_valid), 32'd0);
    tick();
    if_a.din_valid = 1'b0;
    check("t6_start", 32'(if_a.frame_start), 32'd1);
    capture(1'b0, word, nx, nv, ns, ok);
    check("t6_done", 32'(ok), 32'd1);
    check("t6_word", word, E_0C6);
    check("t6_xfer", nx, NB);

    // Reset on the 5th bit discards the frame
    send_a(10'h155);
    repeat (4) tick();
    check("t4_mid_valid", 32'(if_a.sout_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_sout",  32'(if_a.sout),        32'd0);
    check("t4_valid", 32'(if_a.sout_valid),  32'd0);
    check("t4_start", 32'(if_a.frame_start), 32'd0);
    check("t4_busy",  32'(if_a.busy),        32'd0);
    check("t4_ready", 32'(if_a.din_ready),   32'd1);
    repeat (3) tick();
    check("t4_quiet_valid", 32'(if_a.sout_valid), 32'd0);
    check("t4_quiet_busy",  32'(if_a.busy),       32'd0);
    send_a(10'h1A3);
    capture(1'b0, word, nx, nv, ns, ok);
    check("t4_word",  word, E_1A3);
    check("t4_valid_cnt", nv, NB);

    // Parity bit presence / value
    send_a(10'h007);
    capture(1'b0, word, nx, nv, ns, ok);
    check("t5_word_007", word, E_007);
    check("t5_xfer_007", nx, NB);
    send_a(10'h003);
    capture(1'b0, word, nx, nv, ns, ok);
    check("t5_word_003", word, E_003);
    check("t5_xfer_003", nx, NB);

    // Back-to-back frames on the GAP=0 instance
    en = 1'b1;
    if_b.din       = 10'h3FF;
    if_b.din_valid = 1'b1;
    tick();
    if_b.din = 10'h000;
    for (int i = 0; i <= 2 * int'(NB); i++) begin
      exp_sout = (i < 10) ? 1'b1 : 1'b0;
      check($sformatf("t3_valid_%0d", i), 32'(if_b.sout_valid), 32'(i != int'(NB)));
      check($sformatf("t3_ready_%0d", i), 32'(if_b.din_ready),  32'(i == int'(NB)));
      check($sformatf("t3_sout_%0d", i),  32'(if_b.sout),       32'(exp_sout));
      check($sformatf("t3_start_%0d", i), 32'(if_b.frame_start),
            32'((i == 0) || (i == int'(NB) + 1)));
      if (i == int'(NB) + 1) if_b.din_valid = 1'b0;
      tick();
    end
    check("t3_end_valid", 32'(if_b.sout_valid), 32'd0);
    check("t3_end_ready", 32'(if_b.din_ready),  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
